prog_loader: RTL

Byte-stream program loader, the write side of the CPU's instruction memory. It accepts a framed program image over a valid/ready byte interface and writes it sequentially into program memory starting at address 0. It holds the CPU in reset while loading, and releases it only after a frame passes its checksum.

---
 rtl/prog_loader.sv | 93 +++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader writing a program image into instruction memory
module prog_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC       = 8'hA5,
    parameter int         TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LEN, DATA, SUM} state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] len;
    logic [ADDR_WIDTH:0] idx;
    logic [7:0]          sum;
    logic [TW-1:0]       tmo;
    logic                acc;

    assign acc = in_valid && in_ready;

    // frame parser: sync/length/data/checksum sequencing with inter-byte timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            sum       <= '0;
            tmo       <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            if (state != IDLE)
                tmo <= acc ? '0 : tmo + 1'b1;
            case (state)
                IDLE: if (acc && in_data == SYNC) begin
                    state   <= LEN;
                    err     <= 1'b0;
                    cpu_rst <= 1'b1;
                    tmo     <= '0;
                end
                LEN: if (acc) begin
                    len   <= (in_data == 8'd0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : (ADDR_WIDTH+1)'(in_data);
                    idx   <= '0;
                    sum   <= '0;
                    state <= DATA;
                end
                DATA: if (acc) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= idx[ADDR_WIDTH-1:0];
                    mem_wdata <= in_data;
                    idx       <= idx + 1'b1;
                    sum       <= sum + in_data;
                    if (idx + 1'b1 == len)
                        state <= SUM;
                end
                SUM: if (acc) begin
                    if (in_data == sum) begin
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE && !acc && tmo == TW'(TIMEOUT - 1)) begin
                err     <= 1'b1;
                cpu_rst <= 1'b1;
                state   <= IDLE;
            end
        end
    end
endmodule
